// File: rtl/rr_interval_tracker.sv
// RR-interval averaging/threshold engine: two circular histories with O(1) running sums,
// thresholds from a serial shift-add multiplier, one update per COEF_W+3 cycles.
module rr_interval_tracker #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 3,
    parameter int INIT_RR    = 200,
    parameter int COEF_W     = 10,
    parameter int COEF_LOW   = 236,
    parameter int COEF_HIGH  = 297,
    parameter int COEF_MISS  = 425,
    parameter int IRR_LIMIT  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  rr_valid,
    output logic                  rr_ready,
    input  logic [DATA_WIDTH-1:0] rr_interval,
    output logic [DATA_WIDTH-1:0] rravg1,
    output logic [DATA_WIDTH-1:0] rravg2,
    output logic [DATA_WIDTH-1:0] rrlow,
    output logic [DATA_WIDTH-1:0] rrhigh,
    output logic [DATA_WIDTH-1:0] rrmiss,
    output logic                  irregular,
    output logic                  upd_valid
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int SUM_W  = DATA_WIDTH + DEPTH_LOG2;
    localparam int PROD_W = DATA_WIDTH + COEF_W;
    localparam int CNT_W  = (COEF_W > 1) ? $clog2(COEF_W) : 1;
    localparam int IRR_W  = $clog2(IRR_LIMIT + 1);
    localparam int MAXV   = (1 << DATA_WIDTH) - 1;

    localparam int RST_LOW_I  = (INIT_RR * COEF_LOW  + 128) / 256;
    localparam int RST_HIGH_I = (INIT_RR * COEF_HIGH + 128) / 256;
    localparam int RST_MISS_I = (INIT_RR * COEF_MISS + 128) / 256;

    localparam logic [DATA_WIDTH-1:0] INIT_V   = DATA_WIDTH'(INIT_RR);
    localparam logic [SUM_W-1:0]      INIT_SUM = SUM_W'(INIT_RR * DEPTH);
    localparam logic [DATA_WIDTH-1:0] RST_LOW  = DATA_WIDTH'((RST_LOW_I  > MAXV) ? MAXV : RST_LOW_I);
    localparam logic [DATA_WIDTH-1:0] RST_HIGH = DATA_WIDTH'((RST_HIGH_I > MAXV) ? MAXV : RST_HIGH_I);
    localparam logic [DATA_WIDTH-1:0] RST_MISS = DATA_WIDTH'((RST_MISS_I > MAXV) ? MAXV : RST_MISS_I);

    localparam logic [COEF_W-1:0] CL = COEF_W'(COEF_LOW);
    localparam logic [COEF_W-1:0] CH = COEF_W'(COEF_HIGH);
    localparam logic [COEF_W-1:0] CM = COEF_W'(COEF_MISS);

    typedef enum logic [1:0] {IDLE, ACCUM, MUL, DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] buf1 [DEPTH];
    logic [DATA_WIDTH-1:0] buf2 [DEPTH];
    logic [SUM_W-1:0]      sum1, sum2;
    logic [DEPTH_LOG2-1:0] wp1, wp2;
    logic [IRR_W-1:0]      irr_run;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] x_q;
    logic                  in_range_q;
    logic [PROD_W-1:0]     prod_low, prod_high, prod_miss;
    logic                  upd_q;

    logic [DATA_WIDTH-1:0] avg1, avg2, miss_src;
    logic                  resync;

    assign avg1     = sum1[SUM_W-1:DEPTH_LOG2];
    assign avg2     = sum2[SUM_W-1:DEPTH_LOG2];
    assign miss_src = in_range_q ? avg2 : avg1;
    assign resync   = (irr_run == IRR_W'(IRR_LIMIT));

    assign rr_ready  = en && (state == IDLE);
    assign upd_valid = upd_q && en;

    // Q8 product back to integer with round-half-up, clamped to the output width.
    function automatic logic [DATA_WIDTH-1:0] rnd(input logic [PROD_W-1:0] p);
        logic [PROD_W:0] t;
        t = ({1'b0, p} + (PROD_W+1)'(128)) >> 8;
        if (|t[PROD_W:DATA_WIDTH])
            rnd = {DATA_WIDTH{1'b1}};
        else
            rnd = t[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else if (clear)
            state <= IDLE;
        else if (en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rr_valid) state_nxt = ACCUM;
            ACCUM:   state_nxt = MUL;
            MUL:     if (cnt == CNT_W'(COEF_W - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf1[i] <= INIT_V;
                buf2[i] <= INIT_V;
            end
            sum1 <= INIT_SUM;   sum2 <= INIT_SUM;
            wp1 <= '0;          wp2 <= '0;
            irr_run <= '0;      cnt <= '0;
            x_q <= '0;          in_range_q <= 1'b0;
            prod_low <= '0;     prod_high <= '0;    prod_miss <= '0;
            rravg1 <= INIT_V;   rravg2 <= INIT_V;
            rrlow <= RST_LOW;   rrhigh <= RST_HIGH; rrmiss <= RST_MISS;
            irregular <= 1'b0;  upd_q <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf1[i] <= INIT_V;
                buf2[i] <= INIT_V;
            end
            sum1 <= INIT_SUM;   sum2 <= INIT_SUM;
            wp1 <= '0;          wp2 <= '0;
            irr_run <= '0;      cnt <= '0;
            x_q <= '0;          in_range_q <= 1'b0;
            prod_low <= '0;     prod_high <= '0;    prod_miss <= '0;
            rravg1 <= INIT_V;   rravg2 <= INIT_V;
            rrlow <= RST_LOW;   rrhigh <= RST_HIGH; rrmiss <= RST_MISS;
            irregular <= 1'b0;  upd_q <= 1'b0;
        end else begin
            upd_q <= en && (state == DONE);
            if (en) begin
                case (state)
                    IDLE: begin
                        if (rr_valid) begin
                            x_q        <= rr_interval;
                            in_range_q <= (rr_interval >= rrlow) && (rr_interval <= rrhigh);
                        end
                    end
                    ACCUM: begin
                        buf1[wp1] <= x_q;
                        sum1      <= sum1 + SUM_W'(x_q) - SUM_W'(buf1[wp1]);
                        wp1       <= wp1 + 1'b1;
                        if (in_range_q) begin
                            buf2[wp2] <= x_q;
                            sum2      <= sum2 + SUM_W'(x_q) - SUM_W'(buf2[wp2]);
                            wp2       <= wp2 + 1'b1;
                            irr_run   <= '0;
                        end else if (!resync) begin
                            irr_run <= irr_run + 1'b1;
                        end
                        prod_low  <= '0;
                        prod_high <= '0;
                        prod_miss <= '0;
                        cnt       <= '0;
                    end
                    MUL: begin
                        // One coefficient bit per cycle, LSB first; sums are stable here.
                        if (CL[cnt]) prod_low  <= prod_low  + (PROD_W'(avg1)     << cnt);
                        if (CH[cnt]) prod_high <= prod_high + (PROD_W'(avg1)     << cnt);
                        if (CM[cnt]) prod_miss <= prod_miss + (PROD_W'(miss_src) << cnt);
                        cnt <= cnt + 1'b1;
                    end
                    DONE: begin
                        rravg1    <= avg1;
                        rravg2    <= resync ? avg1 : avg2;
                        rrmiss    <= rnd(prod_miss);
                        irregular <= !in_range_q;
                        if (in_range_q || resync) begin
                            rrlow  <= rnd(prod_low);
                            rrhigh <= rnd(prod_high);
                        end
                        // Sustained irregular rhythm: the regular history is rebuilt from all beats.
                        if (resync) begin
                            buf2    <= buf1;
                            sum2    <= sum1;
                            wp2     <= wp1;
                            irr_run <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/rr_interval_tracker.md
Name: rr_interval_tracker

Overview:
Parametrised RR-interval averaging and threshold engine for the Pan-Tompkins back end.
- Keeps two circular histories of accepted RR intervals:
  - all beats (avg1);
  - beats inside the regular window (avg2).
- Maintains O(1) running sums and derives rrlow, rrhigh and rrmiss with a serial shift-add fixed-point multiplier.
- Adds three things the decision stage needs: valid/ready intake, an update strobe, and automatic resynchronisation after sustained irregular rhythm.

Parameters:
DATA_WIDTH, 16, RR interval and threshold width (unsigned, samples)
DEPTH_LOG2, 3, log2 of history depth (depth = 8)
INIT_RR, 200, reset value of every history entry (1000 ms at 200 Hz)
COEF_W, 10, coefficient width; also the number of multiplier cycles
COEF_LOW, 236, rrlow factor, Q8 (0.92)
COEF_HIGH, 297, rrhigh factor, Q8 (1.16)
COEF_MISS, 425, rrmiss factor, Q8 (1.66)
IRR_LIMIT, 4, consecutive irregular beats that trigger resync

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
en  in  1  clock enable; low freezes all state
clear  in  1  synchronous soft reset to reset values
rr_valid  in  1  rr_interval is valid
rr_ready  out  1  block can accept an interval
rr_interval  in  DATA_WIDTH  new RR interval, unsigned
rravg1  out  DATA_WIDTH  mean of all-beat history
rravg2  out  DATA_WIDTH  mean of regular-beat history
rrlow  out  DATA_WIDTH  lower regular limit
rrhigh  out  DATA_WIDTH  upper regular limit
rrmiss  out  DATA_WIDTH  missed-beat limit
irregular  out  1  last beat was outside [rrlow, rrhigh]
upd_valid  out  1  one-cycle strobe; all outputs refreshed

Behaviour:
- Reset (rstn=0, asynchronous) or clear=1 (synchronous, wins over everything):
  - all entries of buf1 and buf2 = INIT_RR; sum1 = sum2 = INIT_RR<<DEPTH_LOG2; write pointers = 0.
  - rravg1 = rravg2 = 200; rrlow = 184; rrhigh = 232; rrmiss = 332.
  - irregular = 0; upd_valid = 0; irr_run = 0; FSM = IDLE.
  - A handshake in the same cycle as clear is dropped.
- en=0: FSM, buffers, sums, counters and outputs hold; rr_ready forced 0; upd_valid forced 0.
- FSM:
  - IDLE: rr_ready = 1. On rr_valid & en, capture x = rr_interval and in_range = (x >= rrlow && x <= rrhigh), using the thresholds current before the update. Go to ACCUM.
  - ACCUM (1 cycle):
    - sum1 += x - buf1[wp1]; buf1[wp1] = x; wp1 wraps modulo depth.
    - If in_range, same update on buf2/sum2/wp2 and irr_run = 0; else irr_run += 1, saturating at IRR_LIMIT.
    - Go to MUL with bit counter = 0.
  - MUL (COEF_W cycles):
    - avg1 = sum1>>DEPTH_LOG2 and avg2 = sum2>>DEPTH_LOG2 (truncating).
    - Three parallel shift-add products, one coefficient bit per cycle, LSB first.
    - Product width DATA_WIDTH+COEF_W.
    - Go to DONE when counter = COEF_W-1.
  - DONE (1 cycle), each result = (product+128)>>8, saturated to 2^DATA_WIDTH-1:
    - in_range: rrlow = avg1*COEF_LOW; rrhigh = avg1*COEF_HIGH; rrmiss = avg2*COEF_MISS; irregular = 0.
    - not in_range: rrlow and rrhigh hold; rrmiss = avg1*COEF_MISS; irregular = 1.
    - If irr_run == IRR_LIMIT (resync):
      - buf2 = buf1, sum2 = sum1, wp2 = wp1, irr_run = 0.
      - rravg2 reports avg1.
      - rrlow = avg1*COEF_LOW and rrhigh = avg1*COEF_HIGH are also applied.
    - rravg1 and rravg2 are registered; upd_valid = 1 for one cycle; return to IDLE.
- Latency and throughput:
  - upd_valid rises COEF_W+2 cycles after the handshake edge (12 at defaults), en permitting.
  - Throughput is one beat per COEF_W+3 cycles.
- Intake rules:
  - rr_valid while rr_ready = 0 is not consumed; the source holds it.
  - rr_interval = 0 is legal (out of range at defaults).
- Outputs change only in DONE, reset, or clear.

Test Plan:
- Reset release -> rrlow = 184, rrhigh = 232, rrmiss = 332, rravg1 = rravg2 = 200, irregular = 0, rr_ready = 1.
- Eight intervals of 200 -> each upd_valid exactly 12 cycles after its handshake; thresholds stay 184/232/332; irregular = 0.
- From reset, one interval of 216 -> rravg1 = rravg2 = 202, rrlow = 186, rrhigh = 234, rrmiss = 335, irregular = 0.
- From reset, one interval of 300 -> rravg1 = 212, rravg2 = 200, rrlow/rrhigh hold at 184/232, rrmiss = 352, irregular = 1.
- From reset, four intervals of 300:
  - 4th update: rravg1 = rravg2 = 250, rrmiss = 415, rrlow = 230, rrhigh = 290, irregular = 1.
  - A following 250 is then in range (irregular = 0).
- en low for 5 cycles during MUL -> upd_valid delayed to 17 cycles, rr_valid not consumed while rr_ready = 0.
- clear asserted mid-MUL -> reset values restored, no upd_valid.
